// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war computer player.
// The LFSR is a 9-bit XNOR Fibonacci register. Its only lock-up value is all-ones.
package tug_pkg;

    localparam int LFSR_WIDTH = 9;
    localparam int LFSR_TAP   = 4;
    localparam logic [LFSR_WIDTH-1:0] LFSR_LOCKUP = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        PRESS = 2'd2,
        HOLD  = 2'd3
    } press_state_t;

    // One XNOR shift: the feedback (bit0 XNOR bit TAP) enters at the top.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_shift(input logic [LFSR_WIDTH-1:0] cur);
        lfsr_shift = {cur[0] ~^ cur[LFSR_TAP], cur[LFSR_WIDTH-1:1]};
    endfunction

endpackage

// File: rtl/tug_lfsr_core.sv
// LFSR register with step enable and recovery from the all-ones lock-up state.
// The value is held while step is low, so the sequence continues across rounds.
module tug_lfsr_core
    import tug_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step,
    output logic [LFSR_WIDTH-1:0] q
);

    logic [LFSR_WIDTH-1:0] q_r;
    logic [LFSR_WIDTH-1:0] next_s;

    // Next value: a normal shift, or zero when the register is stuck at all-ones.
    always_comb begin
        next_s = lfsr_shift(q_r);
        if (q_r == LFSR_LOCKUP) begin
            next_s = {LFSR_WIDTH{1'b0}};
        end else begin
            next_s = lfsr_shift(q_r);
        end
    end

    // LFSR state register: synchronous active-low clear, advances only when step is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_r <= {LFSR_WIDTH{1'b0}};
        end else if (step) begin
            q_r <= next_s;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/cpu_press_scheduler.sv
// Computer-player press scheduler for tug-of-war.
// On a tick, presses when the LFSR value is below the difficulty setting.
// After each press it waits GAP_TICKS ticks before it can press again.
// Optional feature macro: CPU_PRESS_COUNT_EN adds a saturating press_count output.
module cpu_press_scheduler
    import tug_pkg::*;
#(
    parameter int WIDTH     = LFSR_WIDTH,
    parameter int GAP_TICKS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             tick,
    input  logic [WIDTH-1:0] difficulty,
    output logic             press,
    output logic [WIDTH-1:0] lfsr_q,
    output logic             busy
`ifdef CPU_PRESS_COUNT_EN
    ,
    output logic [7:0]       press_count
`endif
);

    localparam logic [7:0] GAP_INIT = 8'(GAP_TICKS);

    press_state_t     state_r;
    press_state_t     next_state_s;
    logic [7:0]       gap_r;
    logic [7:0]       gap_next_s;
    logic             press_r;
    logic             busy_r;
    logic             step_s;
    logic [WIDTH-1:0] lfsr_s;

    // The LFSR runs whenever the player is active.
    assign step_s = (state_r != IDLE);

    tug_lfsr_core u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (step_s),
        .q     (lfsr_s)
    );

    // Next-state logic. The compare uses the LFSR value before this cycle's step.
    always_comb begin
        next_state_s = state_r;
        gap_next_s   = gap_r;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    next_state_s = ARM;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ARM: begin
                if (!enable) begin
                    next_state_s = IDLE;
                end else if (tick && (lfsr_s < difficulty)) begin
                    next_state_s = PRESS;
                end else begin
                    next_state_s = ARM;
                end
            end
            PRESS: begin
                // The pulse always completes. Only the following state depends on enable.
                if (!enable) begin
                    next_state_s = IDLE;
                end else if (GAP_TICKS == 0) begin
                    next_state_s = ARM;
                end else begin
                    next_state_s = HOLD;
                    gap_next_s   = GAP_INIT;
                end
            end
            HOLD: begin
                if (!enable) begin
                    next_state_s = IDLE;
                end else if (tick) begin
                    if (gap_r == 8'd1) begin
                        next_state_s = ARM;
                    end else begin
                        gap_next_s = gap_r - 8'd1;
                    end
                end else begin
                    next_state_s = HOLD;
                end
            end
            default: begin
                next_state_s = IDLE;
                gap_next_s   = 8'd0;
            end
        endcase
    end

    // State, gap counter and registered outputs. press and busy are decoded from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            gap_r   <= 8'd0;
            press_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            gap_r   <= gap_next_s;
            press_r <= (next_state_s == PRESS);
            busy_r  <= (next_state_s != IDLE);
        end
    end

    assign press  = press_r;
    assign busy   = busy_r;
    assign lfsr_q = lfsr_s;

`ifdef CPU_PRESS_COUNT_EN
    logic [7:0] count_r;

    // Saturating press counter. Only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= 8'd0;
        end else if (press_r && (count_r != 8'hFF)) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign press_count = count_r;
`endif

endmodule
